// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, mux/ALU codes and controller states.
// Imported by the controller, its decoder and the datapath bench.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LDA  = 4'h2;
    localparam logic [3:0] OP_STA  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_JMPI = 4'hA;
    localparam logic [3:0] OP_LDAI = 4'hB;
    localparam logic [3:0] OP_STAI = 4'hC;
    localparam logic [3:0] OP_CLR  = 4'hD;
    localparam logic [3:0] OP_RSVD = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] ACC_SRC_ZERO = 2'b00;
    localparam logic [1:0] ACC_SRC_T    = 2'b01;
    localparam logic [1:0] ACC_SRC_BUS  = 2'b10;
    localparam logic [1:0] ACC_SRC_ALU  = 2'b11;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        INDIR = 2'd2,
        HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/datapath_controller_if.sv
// Controller <-> datapath/memory signal bundle.
// master = controller side, slave = datapath/memory side.
interface datapath_controller_if;
    logic [7:0] IReg_Data_Out;
    logic [7:0] Acc_Data_Out;
    logic       mem_ready;

    logic       IReg_En;
    logic       PC_En;
    logic       IAR_En;
    logic       Acc_En;
    logic       Mux_PC_Add_Sel;
    logic       Mux_PC_In_Sel;
    logic       IReg_Buffer_Sel;
    logic       PC_Buffer_Sel;
    logic       IAR_Buffer_Sel;
    logic       Acc_Buffer_Sel;
    logic [1:0] Mux_Acc_In_Sel;
    logic [1:0] ALU_Sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       halted;
    logic       retire;

    modport master (
        input  IReg_Data_Out, Acc_Data_Out, mem_ready,
        output IReg_En, PC_En, IAR_En, Acc_En, Mux_PC_Add_Sel, Mux_PC_In_Sel,
               IReg_Buffer_Sel, PC_Buffer_Sel, IAR_Buffer_Sel, Acc_Buffer_Sel,
               Mux_Acc_In_Sel, ALU_Sel, mem_rd, mem_wr, halted, retire
    );

    modport slave (
        output IReg_Data_Out, Acc_Data_Out, mem_ready,
        input  IReg_En, PC_En, IAR_En, Acc_En, Mux_PC_Add_Sel, Mux_PC_In_Sel,
               IReg_Buffer_Sel, PC_Buffer_Sel, IAR_Buffer_Sel, Acc_Buffer_Sel,
               Mux_Acc_In_Sel, ALU_Sel, mem_rd, mem_wr, halted, retire
    );
endinterface

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier feeding the controller FSM.
// NOP and the reserved opcode decode to no flags at all.
module opcode_decoder
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       uses_mem,
    output logic       is_write,
    output logic       is_indirect,
    output logic       is_jump,
    output logic       is_cond,
    output logic       is_jmpi,
    output logic       is_halt,
    output logic       acc_wr,
    output logic [1:0] acc_src,
    output logic [1:0] alu_op
);

    always_comb begin
        uses_mem    = 1'b0;
        is_write    = 1'b0;
        is_indirect = 1'b0;
        is_jump     = 1'b0;
        is_cond     = 1'b0;
        is_jmpi     = 1'b0;
        is_halt     = 1'b0;
        acc_wr      = 1'b0;
        acc_src     = ACC_SRC_ZERO;
        alu_op      = ALU_ADD;
        case (opcode)
            OP_LDI: begin
                acc_wr  = 1'b1;
                acc_src = ACC_SRC_T;
            end
            OP_CLR: acc_wr = 1'b1;
            OP_LDA: begin
                uses_mem = 1'b1;
                acc_wr   = 1'b1;
                acc_src  = ACC_SRC_BUS;
            end
            OP_STA: begin
                uses_mem = 1'b1;
                is_write = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                uses_mem = 1'b1;
                acc_wr   = 1'b1;
                acc_src  = ACC_SRC_ALU;
                alu_op   = opcode[1:0];
            end
            OP_JMP: is_jump = 1'b1;
            OP_JZ: begin
                is_jump = 1'b1;
                is_cond = 1'b1;
            end
            OP_JMPI: begin
                uses_mem = 1'b1;
                is_jmpi  = 1'b1;
            end
            OP_LDAI: begin
                uses_mem    = 1'b1;
                is_indirect = 1'b1;
                acc_wr      = 1'b1;
                acc_src     = ACC_SRC_BUS;
            end
            OP_STAI: begin
                uses_mem    = 1'b1;
                is_indirect = 1'b1;
                is_write    = 1'b1;
            end
            OP_HLT:  is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/datapath_controller.sv
// Multi-cycle FETCH/EXEC/INDIR/HALT controller for the 8-bit accumulator datapath.
// Outputs are combinational from state, opcode, mem_ready and the accumulator zero test.
module datapath_controller
    import cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    datapath_controller_if.master  bus
);

    state_t     state, state_nxt;
    logic       uses_mem, is_write, is_indirect, is_jump, is_cond, is_jmpi, is_halt, acc_wr;
    logic [1:0] acc_src, alu_op;
    logic       acc_zero;
    logic       unused_operand;

    // The operand field only feeds the datapath's PC adder and Acc mux.
    assign unused_operand = ^bus.IReg_Data_Out[3:0];
    assign acc_zero       = (bus.Acc_Data_Out == 8'h00);

    opcode_decoder u_dec (
        .opcode      (bus.IReg_Data_Out[7:4]),
        .uses_mem    (uses_mem),
        .is_write    (is_write),
        .is_indirect (is_indirect),
        .is_jump     (is_jump),
        .is_cond     (is_cond),
        .is_jmpi     (is_jmpi),
        .is_halt     (is_halt),
        .acc_wr      (acc_wr),
        .acc_src     (acc_src),
        .alu_op      (alu_op)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    // Everything stays 0 while rst is high, so an interrupted access drops immediately.
    always_comb begin
        state_nxt           = state;
        bus.IReg_En         = 1'b0;
        bus.PC_En           = 1'b0;
        bus.IAR_En          = 1'b0;
        bus.Acc_En          = 1'b0;
        bus.Mux_PC_Add_Sel  = 1'b0;
        bus.Mux_PC_In_Sel   = 1'b0;
        bus.IReg_Buffer_Sel = 1'b0;
        bus.PC_Buffer_Sel   = 1'b0;
        bus.IAR_Buffer_Sel  = 1'b0;
        bus.Acc_Buffer_Sel  = 1'b0;
        bus.Mux_Acc_In_Sel  = ACC_SRC_ZERO;
        bus.ALU_Sel         = ALU_ADD;
        bus.mem_rd          = 1'b0;
        bus.mem_wr          = 1'b0;
        bus.halted          = 1'b0;
        bus.retire          = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    bus.PC_Buffer_Sel = 1'b1;
                    bus.mem_rd        = 1'b1;
                    if (bus.mem_ready) begin
                        bus.IReg_En        = 1'b1;
                        bus.PC_En          = 1'b1;
                        bus.Mux_PC_Add_Sel = 1'b1;
                        state_nxt          = EXEC;
                    end
                end
                EXEC: begin
                    if (is_halt) begin
                        bus.retire = 1'b1;
                        state_nxt  = HALT;
                    end else if (!uses_mem) begin
                        bus.retire = 1'b1;
                        state_nxt  = FETCH;
                        if (acc_wr) begin
                            bus.Acc_En         = 1'b1;
                            bus.Mux_Acc_In_Sel = acc_src;
                        end
                        if (is_jump && (!is_cond || acc_zero)) bus.PC_En = 1'b1;
                    end else begin
                        bus.IReg_Buffer_Sel = 1'b1;
                        if (is_indirect) begin
                            // Pointer fetch: latch mem[t] into IAR, finish in INDIR.
                            bus.mem_rd = 1'b1;
                            if (bus.mem_ready) begin
                                bus.IAR_En = 1'b1;
                                state_nxt  = INDIR;
                            end
                        end else if (is_write) begin
                            bus.Acc_Buffer_Sel = 1'b1;
                            bus.mem_wr         = 1'b1;
                            if (bus.mem_ready) begin
                                bus.retire = 1'b1;
                                state_nxt  = FETCH;
                            end
                        end else begin
                            bus.mem_rd  = 1'b1;
                            bus.ALU_Sel = alu_op;
                            if (bus.mem_ready) begin
                                bus.retire = 1'b1;
                                state_nxt  = FETCH;
                                if (is_jmpi) begin
                                    bus.Mux_PC_In_Sel = 1'b1;
                                    bus.PC_En         = 1'b1;
                                end else begin
                                    bus.Acc_En         = 1'b1;
                                    bus.Mux_Acc_In_Sel = acc_src;
                                end
                            end
                        end
                    end
                end
                INDIR: begin
                    bus.IAR_Buffer_Sel = 1'b1;
                    if (is_write) begin
                        bus.Acc_Buffer_Sel = 1'b1;
                        bus.mem_wr         = 1'b1;
                    end else begin
                        bus.mem_rd = 1'b1;
                    end
                    if (bus.mem_ready) begin
                        bus.retire = 1'b1;
                        state_nxt  = FETCH;
                        if (!is_write) begin
                            bus.Acc_En         = 1'b1;
                            bus.Mux_Acc_In_Sel = acc_src;
                        end
                    end
                end
                HALT: bus.halted = 1'b1;
                default: state_nxt = FETCH;
            endcase
        end
    end

endmodule

// File: doc/datapath_controller.md
# datapath_controller

Multi-cycle control unit for the 8-bit accumulator datapath. Fetches instructions from memory at PC, decodes the 4-bit opcode in IReg, and drives every datapath enable, mux select and buffer select, plus the memory read/write strobes. It waits on a memory ready handshake. It sits beside the datapath in the CPU top level and shares `clk`/`rst` with it.

## Interface
- No parameters.
- `clk` in 1: single clock, all state changes on rising edge.
- `rst` in 1: reset is synchronous and active-high; forces state FETCH, all outputs 0 while asserted.
- `IReg_Data_Out` in 8: instruction; [7:4] opcode, [3:0] operand `t` (zero-extended).
- `Acc_Data_Out` in 8: accumulator, used for the zero test.
- `mem_ready` in 1: memory completes the current read/write this cycle.
- `IReg_En`, `PC_En`, `IAR_En`, `Acc_En` out 1: datapath register enables.
- `Mux_PC_Add_Sel` out 1: 1 = +1, 0 = +t.
- `Mux_PC_In_Sel` out 1: 1 = load PC from Data_Bus_In.
- `IReg_Buffer_Sel`, `PC_Buffer_Sel`, `IAR_Buffer_Sel`, `Acc_Buffer_Sel` out 1: address/data bus drivers.
- `Mux_Acc_In_Sel` out 2: 00 zero, 01 t, 10 Data_Bus_In, 11 ALU.
- `ALU_Sel` out 2: 00 add, 01 sub, 10 and, 11 or.
- `mem_rd`, `mem_wr` out 1: memory strobes.
- `halted` out 1: high in HALT.
- `retire` out 1: one-cycle pulse per completed instruction.

## Operation
- States: FETCH, EXEC, INDIR, HALT. Outputs are combinational from state, opcode, `mem_ready` and `Acc_Data_Out`. Any output not listed below is 0.
- FETCH: `PC_Buffer_Sel`, `mem_rd`. When `mem_ready`=1: `IReg_En`, `PC_En`, `Mux_PC_Add_Sel`=1, go to EXEC. Otherwise hold.
- EXEC, by opcode:
  - 0x0 NOP and 0xE (reserved): no action.
  - 0x1 LDI: Acc <= t (sel 01, `Acc_En`).
  - 0xD CLR: Acc <= 0 (sel 00, `Acc_En`).
  - 0x2 LDA: `IReg_Buffer_Sel`, `mem_rd`; on ready, sel 10, `Acc_En`.
  - 0x3 STA: `IReg_Buffer_Sel`, `Acc_Buffer_Sel`, `mem_wr`; completes on ready.
  - 0x4/5/6/7 ADD/SUB/AND/OR: `IReg_Buffer_Sel`, `mem_rd`, `ALU_Sel` = opcode[1:0]; on ready, sel 11, `Acc_En`.
  - 0x8 JMP: `PC_En`, `Mux_PC_Add_Sel`=0, so PC <= PC + t. The jump is relative to the next instruction.
  - 0x9 JZ: same as JMP, but only if `Acc_Data_Out`==0; otherwise no action.
  - 0xA JMPI: `IReg_Buffer_Sel`, `mem_rd`; on ready, `Mux_PC_In_Sel`=1, `PC_En`, so PC <= mem[t].
  - 0xB LDAI / 0xC STAI: `IReg_Buffer_Sel`, `mem_rd`; on ready, `IAR_En`, go to INDIR.
  - 0xF HLT: go to HALT.
- INDIR: `IAR_Buffer_Sel` drives the address.
  - LDAI: `mem_rd`; on ready, sel 10, `Acc_En`.
  - STAI: `Acc_Buffer_Sel`, `mem_wr`; on ready, complete.
- Completion: EXEC/INDIR go to FETCH and `retire`=1 in the completing cycle. HLT asserts `retire` in EXEC and enters HALT.
- Memory states hold while `mem_ready`=0. In those cycles the strobes and bus selects stay asserted and every register enable stays 0.
- Non-memory instructions ignore `mem_ready`.
- HALT: `halted`=1, all other outputs 0. The only exit is `rst`.

## Timing
- Reset value: every output 0, `halted` 0. The first FETCH occurs in the cycle after `rst` deasserts; the datapath resets PC to 0.
- Latency with `mem_ready` tied 1:
  - 2 cycles for all non-indirect instructions.
  - 3 cycles for LDAI/STAI.
  - Each wait cycle adds 1.
- At most one of `mem_rd`/`mem_wr` is ever high. `PC_Buffer_Sel` and `IReg_Buffer_Sel` are never high together.
- `rst` mid-access (including during `mem_wr`): outputs drop in the same cycle (gated by `rst`). The state is FETCH at the next edge, and the partial instruction is discarded with no `retire`.
- JMP/JZ arithmetic is 8-bit modulo 256: PC 0xFE + 4 = 0x02.
- JZ samples Acc in its EXEC cycle.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants (OP_NOP..OP_HLT);
  - ALU_Sel codes;
  - Mux_Acc_In_Sel codes;
  - state enum.
- The datapath testbench imports the same package.
- One combinational sub-module, `opcode_decoder`: maps an opcode to class flags (uses_mem, is_write, is_indirect, is_jump, acc_src, alu_op).

## Test plan
- Reset, then NOP at mem[0] with ready=1 → FETCH/EXEC alternate, `retire` every 2nd cycle, `PC_Buffer_Sel` high in FETCH.
- LDI 0x15 then ADD 0x47 (mem[7]=0x03) → EXEC of ADD shows `IReg_Buffer_Sel`=1, `ALU_Sel`=00, sel 11, `Acc_En`=1; Acc becomes 0x08.
- CLR, then JZ 0x93 at PC 0x05 → `PC_En` with add-sel 0, PC becomes 0x09. Repeat with Acc=1 → no `PC_En`.
- STAI 0xC2 (mem[2]=0x30) with `mem_ready` low for 2 cycles in INDIR → `mem_wr` and `IAR_Buffer_Sel` held 3 cycles, `retire` only on the ready cycle.
- `rst` pulsed during a held STA write → `mem_wr` 0 in the same cycle, FETCH next, no `retire`.
- HLT 0xF0 → `retire` pulse, then `halted`=1 with all outputs 0 for 10+ cycles, regardless of `mem_ready`.
